// File: rtl/axis_rgb_unpack.sv
// AXI-Stream RGB pixel unpacker.
// Beats carrying {8'h00, red, green, blue} with tuser = start of frame and
// tlast = end of line pass through a small FIFO and are replayed as a
// registered pixel stream framed by sof/eol. After every line a fixed
// horizontal blank of HBLANK idle cycles is inserted. Lines ending early or
// late pulse line_err; an unexpected start of frame pulses frame_err and
// restarts the frame.
// Optional build macro RGB_STAT_EN adds frame_cnt and err_cnt outputs.
module axis_rgb_unpack #(
  parameter int unsigned IMG_WIDTH  = 64,
  parameter int unsigned IMG_HEIGHT = 48,
  parameter int unsigned HBLANK     = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        s_axis_mm2s_tvalid,
  output logic        s_axis_mm2s_tready,
  input  logic [31:0] s_axis_mm2s_tdata,
  input  logic        s_axis_mm2s_tuser,
  input  logic        s_axis_mm2s_tlast,
  output logic        valid,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        sof,
  output logic        eol,
  output logic        line_err,
  output logic        frame_err
`ifdef RGB_STAT_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = $clog2(IMG_WIDTH + 1);
  localparam int unsigned LW = $clog2(IMG_HEIGHT + 1);
  localparam logic [PW-1:0] PixLast   = PW'(IMG_WIDTH);
  localparam logic [LW-1:0] LineLast  = LW'(IMG_HEIGHT - 1);
  localparam logic [7:0]    BlankLast = 8'(HBLANK - 1);

  typedef enum logic [1:0] {
    StWaitSof,
    StActive,
    StBlank
  } state_e;

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [25:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   wr_ptr_seen_q;
  logic [AW:0]   rd_ptr_q;
  logic          rdy_q;
  logic          full;
  logic          avail;
  logic          push;
  logic          pop;
  logic [25:0]   head;
  logic          head_user;
  logic          head_last;
  logic [23:0]   head_pix;
  logic          unused_tdata_hi;

  // Frame sequencing
  state_e        state_q, state_d;
  logic [PW-1:0] pix_q, pix_d, pix_next;
  logic [LW-1:0] line_q, line_d;
  logic [7:0]    blank_q, blank_d;
  logic          at_width;
  logic          emit;
  logic          sof_d, eol_d, lerr_d, ferr_d;

  assign unused_tdata_hi = ^s_axis_mm2s_tdata[31:24];

  assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign s_axis_mm2s_tready = rdy_q & ~full;
  assign push = s_axis_mm2s_tvalid & s_axis_mm2s_tready;
  // The read side sees writes one cycle late, giving a fixed two-cycle
  // accept-to-output latency.
  assign avail = (rd_ptr_q != wr_ptr_seen_q);

  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign head_user = head[25];
  assign head_last = head[24];
  assign head_pix  = head[23:0];

  // FIFO pointers and ready; reset flushes everything buffered.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr_q      <= '0;
      wr_ptr_seen_q <= '0;
      rd_ptr_q      <= '0;
      rdy_q         <= 1'b0;
    end else begin
      rdy_q         <= 1'b1;
      wr_ptr_seen_q <= wr_ptr_q;
      if (push) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
    end
  end

  // FIFO storage write.
  always_ff @(posedge ACLK) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {s_axis_mm2s_tuser, s_axis_mm2s_tlast,
                                  s_axis_mm2s_tdata[23:0]};
    end
  end

  // Next state, pops and output markers.
  always_comb begin
    state_d  = state_q;
    pix_d    = pix_q;
    line_d   = line_q;
    blank_d  = blank_q;
    pop      = 1'b0;
    emit     = 1'b0;
    sof_d    = 1'b0;
    eol_d    = 1'b0;
    lerr_d   = 1'b0;
    ferr_d   = 1'b0;
    pix_next = pix_q + PW'(1);
    at_width = 1'b0;

    case (state_q)
      StWaitSof: begin
        // Heads without start of frame are dropped silently.
        if (avail) begin
          pop = 1'b1;
          if (head_user) begin
            emit     = 1'b1;
            sof_d    = 1'b1;
            line_d   = '0;
            pix_next = PW'(1);
          end
        end
      end
      StActive: begin
        if (avail) begin
          pop  = 1'b1;
          emit = 1'b1;
          if (head_user) begin
            ferr_d   = 1'b1;
            sof_d    = 1'b1;
            line_d   = '0;
            pix_next = PW'(1);
          end
        end
      end
      StBlank: begin
        if (blank_q == BlankLast) begin
          blank_d = '0;
          pix_d   = '0;
          if (line_q == LineLast) begin
            state_d = StWaitSof;
            line_d  = '0;
          end else begin
            state_d = StActive;
            line_d  = line_q + LW'(1);
          end
        end else begin
          blank_d = blank_q + 8'd1;
        end
      end
      default: state_d = StWaitSof;
    endcase

    // Line ends on tlast or on the width limit; disagreement is an error.
    if (emit) begin
      at_width = (pix_next == PixLast);
      pix_d    = pix_next;
      if (head_last || at_width) begin
        eol_d   = 1'b1;
        lerr_d  = head_last ^ at_width;
        state_d = StBlank;
        blank_d = '0;
      end else begin
        state_d = StActive;
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= StWaitSof;
      pix_q   <= '0;
      line_q  <= '0;
      blank_q <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      blank_q <= blank_d;
    end
  end

  // Registered pixel output; colour holds its last value when idle.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      valid     <= 1'b0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      line_err  <= 1'b0;
      frame_err <= 1'b0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
    end else begin
      valid     <= emit;
      sof       <= sof_d;
      eol       <= eol_d;
      line_err  <= lerr_d;
      frame_err <= ferr_d;
      if (emit) {red, green, blue} <= head_pix;
    end
  end

`ifdef RGB_STAT_EN
  logic        frame_done;
  logic [16:0] err_sum;

  assign frame_done = (state_q == StBlank) && (blank_q == BlankLast) && (line_q == LineLast);

  // Both error kinds in one cycle count twice, clamped at all-ones.
  always_comb begin
    err_sum = {1'b0, err_cnt} + {16'b0, lerr_d} + {16'b0, ferr_d};
  end

  // Frame and error statistics.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
      err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_axis_rgb_unpack.sv
// Bench for axis_rgb_unpack: table of beats with expected pixels feeding a
// scoreboard queue, plus hand-written latency, reset and stall sequences.
// Instance a uses HBLANK=2, instance b uses HBLANK=16 for the stall case.
module tb_axis_rgb_unpack;

  localparam int unsigned W     = 4;
  localparam int unsigned H     = 2;
  localparam int unsigned HB    = 2;
  localparam int unsigned HB_B  = 16;
  localparam int unsigned DEPTH = 4;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic        tvalid, tready, tuser, tlast;
  logic [31:0] tdata;
  logic        valid, sof, eol, line_err, frame_err;
  logic [7:0]  red, green, blue;

  logic        b_tvalid, b_tready, b_tuser, b_tlast;
  logic [31:0] b_tdata;
  logic        b_valid, b_sof, b_eol, b_line_err, b_frame_err;
  logic [7:0]  b_red, b_green, b_blue;
`ifdef RGB_STAT_EN
  logic [15:0] frame_cnt, err_cnt, b_frame_cnt, b_err_cnt;
`endif

  axis_rgb_unpack #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .HBLANK(HB), .FIFO_DEPTH(DEPTH)) dut_a (
    .ACLK(aclk), .ARESETN(aresetn),
    .s_axis_mm2s_tvalid(tvalid), .s_axis_mm2s_tready(tready),
    .s_axis_mm2s_tdata(tdata), .s_axis_mm2s_tuser(tuser), .s_axis_mm2s_tlast(tlast),
    .valid(valid), .red(red), .green(green), .blue(blue),
    .sof(sof), .eol(eol), .line_err(line_err), .frame_err(frame_err)
`ifdef RGB_STAT_EN
    , .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`endif
  );

  axis_rgb_unpack #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .HBLANK(HB_B), .FIFO_DEPTH(DEPTH)) dut_b (
    .ACLK(aclk), .ARESETN(aresetn),
    .s_axis_mm2s_tvalid(b_tvalid), .s_axis_mm2s_tready(b_tready),
    .s_axis_mm2s_tdata(b_tdata), .s_axis_mm2s_tuser(b_tuser), .s_axis_mm2s_tlast(b_tlast),
    .valid(b_valid), .red(b_red), .green(b_green), .blue(b_blue),
    .sof(b_sof), .eol(b_eol), .line_err(b_line_err), .frame_err(b_frame_err)
`ifdef RGB_STAT_EN
    , .frame_cnt(b_frame_cnt), .err_cnt(b_err_cnt)
`endif
  );

  typedef struct packed {
    logic [23:0] rgb;
    logic        sof;
    logic        eol;
    logic        lerr;
    logic        ferr;
  } out_t;

  typedef struct {
    logic        user;
    logic        last;
    logic [31:0] data;
    logic        emit;
    out_t        exp;
  } vec_t;

  vec_t vec[$];
  out_t exp_q[$];
  out_t b_q[$];
  int   checks = 0;
  int   passes = 0;
  int   seq = 0;
  int   cyc = 0;
  int   eol_cyc = -1;
  int   b_eol_cyc = -1;
  int   b_outs = 0;
  int   b_acc = 0;
  logic gap_en = 1'b0;
  logic full_seen;
  out_t a_got, a_want, b_got, b_want;
  int   mark[7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h, want %h", name, got, want);
  endtask

  // Append one beat with its expected output (if any) to the table.
  task automatic add(input logic u, input logic l, input logic emit, input logic s,
                     input logic e, input logic le, input logic fe);
    vec_t v;
    logic [31:0] d;
    d = {8'hE5, 8'(seq), 8'(8'hA0 + seq), 8'(8'h3C ^ seq)};
    v.user = u;
    v.last = l;
    v.data = d;
    v.emit = emit;
    v.exp  = emit ? {d[23:0], s, e, le, fe} : '0;
    vec.push_back(v);
    seq++;
  endtask

  task automatic clean_frame();
    add(1, 0, 1, 1, 0, 0, 0);
    repeat (2) add(0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 0, 0);
    repeat (3) add(0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 0, 0);
  endtask

  // Called just after a negedge; returns at the negedge after acceptance.
  task automatic send(input logic u, input logic l, input logic [31:0] d);
    int n;
    tvalid = 1'b1;
    tuser  = u;
    tlast  = l;
    tdata  = d;
    n = 0;
    while (!tready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (!tready) begin
      checks++;
      $display("FAIL send_timeout: tready stuck at 0, want 1 within 200 cycles");
    end
    @(negedge aclk);
  endtask

  task automatic run_vec(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      if (vec[i].emit) exp_q.push_back(vec[i].exp);
      send(vec[i].user, vec[i].last, vec[i].data);
    end
    tvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge aclk);
      n++;
    end
    chk(name, 32'(exp_q.size()), 0);
    repeat (HB_B + 8) @(negedge aclk);
  endtask

  always @(posedge aclk) cyc <= cyc + 1;

  // Scoreboard for instance a, plus blank-length check after each eol.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (valid) begin
        a_got = {red, green, blue, sof, eol, line_err, frame_err};
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL a_unexpected_pixel: got %h, want no output", a_got);
        end else begin
          a_want = exp_q.pop_front();
          chk("a_pixel", 32'(a_got), 32'(a_want));
        end
        if (gap_en && eol_cyc >= 0) chk("a_blank_gap", 32'(cyc - eol_cyc), HB + 1);
        eol_cyc = eol ? cyc : -1;
      end else if (sof || eol || line_err || frame_err) begin
        checks++;
        $display("FAIL a_marker_without_valid: got %b%b%b%b, want 0000",
                 sof, eol, line_err, frame_err);
      end
      if (!gap_en) eol_cyc = -1;
    end
  end

  // Scoreboard for instance b.
  always @(negedge aclk) begin
    if (aresetn && b_valid) begin
      b_got = {b_red, b_green, b_blue, b_sof, b_eol, b_line_err, b_frame_err};
      if (b_q.size() == 0) begin
        checks++;
        $display("FAIL b_unexpected_pixel: got %h, want no output", b_got);
      end else begin
        b_want = b_q.pop_front();
        chk("b_pixel", 32'(b_got), 32'(b_want));
      end
      b_outs++;
      if (b_eol_cyc >= 0) chk("b_blank_gap", 32'(cyc - b_eol_cyc), HB_B + 1);
      b_eol_cyc = b_eol ? cyc : -1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0; tdata = '0;
    b_tvalid = 1'b0; b_tuser = 1'b0; b_tlast = 1'b0; b_tdata = '0;

    // Rest of the first frame after the hand-sent first pixel.
    mark[0] = vec.size();
    repeat (2) add(0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 0, 0);
    repeat (3) add(0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 0, 0);
    // Clean back-to-back frame.
    mark[1] = vec.size();
    clean_frame();
    // Three non-sof beats discarded, then a clean frame.
    mark[2] = vec.size();
    repeat (3) add(0, 0, 0, 0, 0, 0, 0);
    clean_frame();
    // Short line (tlast on pixel 3) and long line (6 pixels, no tlast).
    mark[3] = vec.size();
    add(1, 0, 1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 1, 0);
    repeat (3) add(0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 1, 1, 0);
    repeat (2) add(0, 0, 0, 0, 0, 0, 0);
    // Unexpected sof mid-line restarts the frame.
    mark[4] = vec.size();
    add(1, 0, 1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 0, 1);
    repeat (2) add(0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 0, 0);
    repeat (3) add(0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 0, 0);
    // Two pixels into a line before reset, then a clean frame after it.
    mark[5] = vec.size();
    add(1, 0, 1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0);
    mark[6] = vec.size();
    clean_frame();

    // Reset state.
    repeat (3) @(negedge aclk);
    chk("reset_outputs", 32'({tready, valid, sof, eol, line_err, frame_err, red, green, blue}), 0);
`ifdef RGB_STAT_EN
    chk("reset_stats", {frame_cnt, err_cnt}, 0);
`endif
    aresetn = 1'b1;
    @(negedge aclk);
    chk("tready_after_reset", 32'(tready), 1);

    // First-pixel latency and channel split.
    tvalid = 1'b1; tuser = 1'b1; tlast = 1'b0; tdata = 32'hAB123456;
    exp_q.push_back({24'h123456, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge aclk);
    tvalid = 1'b0;
    chk("lat_after_k", 32'(valid), 0);
    @(negedge aclk);
    chk("lat_after_k1", 32'(valid), 0);
    @(negedge aclk);
    chk("lat_after_k2", 32'(valid), 1);
    chk("lat_red", 32'(red), 32'h12);
    chk("lat_green", 32'(green), 32'h34);
    chk("lat_blue", 32'(blue), 32'h56);

    gap_en = 1'b1;
    run_vec(mark[0], mark[1]);
    run_vec(mark[1], mark[2]);
    drain("drain_clean");
    gap_en = 1'b0;

    run_vec(mark[2], mark[3]);
    drain("drain_discard");
    run_vec(mark[3], mark[4]);
    drain("drain_line_err");
    run_vec(mark[4], mark[5]);
    drain("drain_frame_err");
`ifdef RGB_STAT_EN
    chk("stat_frames", 32'(frame_cnt), 5);
    chk("stat_errors", 32'(err_cnt), 3);
`endif

    // Reset mid-line with a start-of-frame beat still buffered.
    run_vec(mark[5], mark[6]);
    drain("drain_pre_reset");
    send(1'b1, 1'b0, 32'h00DEAD00);
    tvalid = 1'b0;
    aresetn = 1'b0;
    #1;
    chk("reset_mid_line", 32'({tready, valid, sof, eol, line_err, frame_err, red, green, blue}), 0);
    @(negedge aclk);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
`ifdef RGB_STAT_EN
    chk("stat_after_reset", 32'(frame_cnt), 0);
`endif
    run_vec(mark[6], vec.size());
    drain("drain_post_reset");

    // Long blank with tvalid held: FIFO fills, nothing lost or repeated.
    full_seen = 1'b0;
    b_acc = 0;
    for (int i = 0; i < 16; i++) begin
      int n;
      logic [31:0] d;
      d = {8'h7F, 8'(i), 8'(8'hF0 - i), 8'(i * 9)};
      b_tvalid = 1'b1;
      b_tuser  = (i % 8 == 0);
      b_tlast  = (i % 4 == 3);
      b_tdata  = d;
      n = 0;
      while (!b_tready && n < 100) begin
        if (!full_seen) begin
          full_seen = 1'b1;
          chk("b_fifo_fill", 32'(b_acc - b_outs), DEPTH);
        end
        @(negedge aclk);
        n++;
      end
      if (!b_tready) begin
        checks++;
        $display("FAIL b_accept_timeout: beat %0d tready 0, want 1", i);
      end
      b_q.push_back({d[23:0], b_tuser, b_tlast, 1'b0, 1'b0});
      b_acc++;
      @(negedge aclk);
    end
    b_tvalid = 1'b0;
    chk("b_tready_fell", 32'(full_seen), 1);
    for (int n = 0; n < 1000 && b_q.size() != 0; n++) @(negedge aclk);
    repeat (HB_B + 8) @(negedge aclk);
    chk("b_queue_empty", 32'(b_q.size()), 0);
    chk("b_output_count", 32'(b_outs), 16);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
